// File: rtl/mac_stop_pkg.sv
// mac_stop_pkg: shared selector/state types and result-width helper for the MAC-stop matrix store
package mac_stop_pkg;
  typedef enum logic [1:0] {SEL_A, SEL_B, SEL_C, SEL_NONE} sel_t;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  function automatic int res_w(input int w, input int k);
    return 2 * w + $clog2(k);
  endfunction
endpackage

// File: rtl/mac_stop_op_seq.sv
// mac_stop_op_seq: stream FSM walking i (outer), j, k (inner) over every operand pair with valid/ready
module mac_stop_op_seq import mac_stop_pkg::*; #(
  parameter int M = 3,
  parameter int K = 5,
  parameter int N = 5,
  localparam int MW = $clog2(M),
  localparam int KW = $clog2(K),
  localparam int NW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          op_ready,
  output logic          busy,
  output logic          done,
  output logic          op_valid,
  output logic          op_last,
  output logic [MW-1:0] op_row,
  output logic [NW-1:0] op_col,
  output logic [KW-1:0] op_k
);
  state_t state, state_n;
  logic hs, last_i, last_j, last_k;
  always_comb begin
    last_i = op_row == MW'(M - 1);
    last_j = op_col == NW'(N - 1);
    last_k = op_k == KW'(K - 1);
    busy = state == STREAM;
    op_valid = busy;
    done = state == DONE;
    op_last = busy && last_k;
    hs = busy && op_ready;
    state_n = state == IDLE ? (start ? STREAM : IDLE) :
              state == STREAM ? (hs && last_i && last_j && last_k ? DONE : STREAM) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_row <= '0;
      op_col <= '0;
      op_k <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        op_row <= '0;
        op_col <= '0;
        op_k <= '0;
      end else if (hs) begin
        op_k <= last_k ? '0 : op_k + 1'b1;
        if (last_k) op_col <= last_j ? '0 : op_col + 1'b1;
        if (last_k && last_j) op_row <= last_i ? '0 : op_row + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mac_stop_mem_stream.sv
// mac_stop_mem_stream: A/B/C register store with host port, operand streaming engine and C write-back
module mac_stop_mem_stream import mac_stop_pkg::*; #(
  parameter int M = 3,
  parameter int K = 5,
  parameter int N = 5,
  parameter int DATA_WIDTH_INIT_MATRIX = 32,
  localparam int DATA_WIDTH_RESULT_MATRIX = res_w(DATA_WIDTH_INIT_MATRIX, K),
  localparam int W = DATA_WIDTH_INIT_MATRIX,
  localparam int RES_W = DATA_WIDTH_RESULT_MATRIX,
  localparam int RW = $clog2(M > K ? M : K),
  localparam int CW = $clog2(K > N ? K : N),
  localparam int MW = $clog2(M),
  localparam int KW = $clog2(K),
  localparam int NW = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       host_sel,
  input  logic [RW-1:0]    host_row,
  input  logic [CW-1:0]    host_col,
  input  logic             host_we,
  input  logic             host_re,
  input  logic [RES_W-1:0] host_wdata,
  output logic [RES_W-1:0] host_rdata,
  output logic             host_rvalid,
  output logic             host_conflict,
  input  logic             clear_c,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  output logic [MW-1:0]    op_row,
  output logic [NW-1:0]    op_col,
  output logic [KW-1:0]    op_k,
  output logic             op_last,
  input  logic             res_valid,
  input  logic [MW-1:0]    res_row,
  input  logic [NW-1:0]    res_col,
  input  logic [RES_W-1:0] res_data,
  input  logic             accum_mode
);
  logic [W-1:0] a [M][K];
  logic [W-1:0] b [K][N];
  logic [RES_W-1:0] c [M][N];
  logic in_a, in_b, in_c, clr, res_hit, host_c, wr_a, wr_b;
  logic [RES_W-1:0] rd;
  sel_t sel;
  mac_stop_op_seq #(.M(M), .K(K), .N(N)) u_seq (
    .clk(clk), .reset(reset), .start(start), .op_ready(op_ready),
    .busy(busy), .done(done), .op_valid(op_valid), .op_last(op_last),
    .op_row(op_row), .op_col(op_col), .op_k(op_k)
  );
  always_comb begin
    sel = sel_t'(host_sel);
    in_a = int'(host_row) < M && int'(host_col) < K;
    in_b = int'(host_row) < K && int'(host_col) < N;
    in_c = int'(host_row) < M && int'(host_col) < N;
    clr = clear_c && !busy;
    res_hit = res_valid && int'(res_row) < M && int'(res_col) < N;
    host_c = host_we && sel == SEL_C && in_c;
    wr_a = host_we && sel == SEL_A && in_a && !busy;
    wr_b = host_we && sel == SEL_B && in_b && !busy;
    rd = sel == SEL_A && in_a ? RES_W'(a[host_row[MW-1:0]][host_col[KW-1:0]]) :
         sel == SEL_B && in_b ? RES_W'(b[host_row[KW-1:0]][host_col[NW-1:0]]) :
         sel == SEL_C && in_c ? c[host_row[MW-1:0]][host_col[NW-1:0]] : '0;
    op_a = op_valid ? a[op_row][op_k] : '0;
    op_b = op_valid ? b[op_k][op_col] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a <= '{default: '0};
      b <= '{default: '0};
      c <= '{default: '0};
      host_rdata <= '0;
      host_rvalid <= 1'b0;
      host_conflict <= 1'b0;
    end else begin
      host_rvalid <= host_re;
      host_rdata <= host_re ? rd : '0;
      host_conflict <= host_c && (clr || res_hit);
      if (wr_a) a[host_row[MW-1:0]][host_col[KW-1:0]] <= host_wdata[W-1:0];
      if (wr_b) b[host_row[KW-1:0]][host_col[NW-1:0]] <= host_wdata[W-1:0];
      if (clr) c <= '{default: '0};
      else if (res_hit) c[res_row][res_col] <= accum_mode ? c[res_row][res_col] + res_data : res_data;
      else if (host_c) c[host_row[MW-1:0]][host_col[NW-1:0]] <= host_wdata;
    end
  end
endmodule
